// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-4 Booth partial-product datapath.
// Holds width defaults, the accumulator FSM states and the beat-correction helper.
package booth_pkg;

  localparam int A_W   = 11;
  localparam int B_W   = 11;
  localparam int N_DIG = (B_W + 2) / 2;
  localparam int P_W   = A_W + B_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // {neg, mag} carries ~m for negative digits; adding neg completes the negation
  function automatic logic signed [A_W+1:0] beat_val(
    input logic         neg,
    input logic [A_W:0] mag
  );
    return $signed({neg, mag}) + $signed({{(A_W + 1){1'b0}}, neg});
  endfunction

endpackage

// File: rtl/booth_pp_correct.sv
// Sign correction of one Booth partial product: {neg, mag} to a signed beat.
// Purely combinational so a parallel reduction tree can reuse it.
module booth_pp_correct #(
  parameter int A_W = booth_pkg::A_W
) (
  input  logic                pp_neg,
  input  logic [A_W:0]        pp_mag,
  output logic signed [A_W+1:0] beat
);

  assign beat = $signed({pp_neg, pp_mag})
              + $signed({{(A_W + 1){1'b0}}, pp_neg});

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth partial-product accumulator (one digit per beat).
// Define BOOTH_ACC_CHECK_EN to build the pp_last sequence checker (res_err).
module booth_pp_accumulator #(
  parameter int A_W   = booth_pkg::A_W,
  parameter int N_DIG = booth_pkg::N_DIG,
  parameter int P_W   = booth_pkg::P_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pp_valid,
  output logic           pp_ready,
  input  logic [A_W:0]   pp_mag,
  input  logic           pp_neg,
  input  logic           pp_last,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [P_W-1:0] res_product,
  output logic           res_err
);

  import booth_pkg::*;

  localparam int CW    = $clog2(N_DIG + 1);
  localparam int ACC_W = P_W + 2;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   ext, term;
  logic        [CW-1:0]      cnt_q, cnt_d;
  logic signed [A_W+1:0]     beat;
  logic                      accept;
  logic                      last_dig;
  logic        [1:0]         unused_acc;

  booth_pp_correct #(
    .A_W (A_W)
  ) u_correct (
    .pp_neg (pp_neg),
    .pp_mag (pp_mag),
    .beat   (beat)
  );

  assign pp_ready  = (state_q != DONE);
  assign res_valid = (state_q == DONE);
  assign accept    = pp_valid && pp_ready;
  assign last_dig  = (cnt_q == CW'(N_DIG - 1));

  assign ext  = {{(P_W - A_W){beat[A_W+1]}}, beat};
  assign term = ext <<< {cnt_q, 1'b0};

  // final sum is always non-negative and fits P_W bits
  assign res_product = acc_q[P_W-1:0];
  assign unused_acc  = acc_q[ACC_W-1:P_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = ((state_q == IDLE) ? '0 : acc_q) + term;
          cnt_d   = cnt_q + 1'b1;
          state_d = last_dig ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BOOTH_ACC_CHECK_EN
  logic err_q, err_d;

  // pp_last must coincide exactly with the final digit
  always_comb begin
    err_d = err_q;
    if (accept)
      err_d = err_q | (pp_last ^ last_dig);
    else if (res_valid && res_ready)
      err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign res_err = err_q;
`else
  logic unused_last;

  assign unused_last = pp_last;
  assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator with an expected-product scoreboard.
// Encodes B into Booth digits locally and checks products against A*B.
module tb_booth_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pp_valid;
  logic        pp_ready;
  logic [11:0] pp_mag;
  logic        pp_neg;
  logic        pp_last;
  logic        res_valid;
  logic        res_ready;
  logic [21:0] res_product;
  logic        res_err;

  typedef struct {
    logic [21:0] p;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  booth_pp_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pp_valid    (pp_valid),
    .pp_ready    (pp_ready),
    .pp_mag      (pp_mag),
    .pp_neg      (pp_neg),
    .pp_last     (pp_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
    .res_err     (res_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic neg, input logic [11:0] mag,
                           input logic last);
    int t = 0;
    pp_valid = 1'b1;
    pp_neg   = neg;
    pp_mag   = mag;
    pp_last  = last;
    while (!pp_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!pp_ready) chk("beat_timeout", pp_ready, 1);
    @(posedge clk);
    @(negedge clk);
    pp_valid = 1'b0;
  endtask

  task automatic collect(input bit lat);
    int   t = 0;
    exp_t x;
    if (lat) chk("latency", res_valid, 1);
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!res_valid) chk("res_timeout", res_valid, 1);
    x = sb.pop_front();
    chk("product", res_product, x.p);
    chk("err", res_err, x.e);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ready_after_hs", pp_ready, 1);
  endtask

  // nb < 6 sends a truncated stream and expects nothing
  task automatic send_prod(input int a, input int b, input bit stall,
                           input int last_at, input int nb, input bit lat,
                           input bit get);
    int   b2, b1, b0, d, m;
    logic [11:0] mag;
    logic neg;
    exp_t x;
    if (nb == 6) begin
      x.p = 22'(a * b);
`ifdef BOOTH_ACC_CHECK_EN
      x.e = (last_at != 6);
`else
      x.e = 1'b0;
`endif
      sb.push_back(x);
    end
    for (int i = 0; i < nb; i++) begin
      b2 = (b >> (2 * i + 1)) & 1;
      b1 = (b >> (2 * i)) & 1;
      b0 = (i == 0) ? 0 : ((b >> (2 * i - 1)) & 1);
      d  = b1 + b0 - 2 * b2;
      m  = ((d < 0) ? -d : d) * a;
      neg = (d < 0);
      mag = neg ? ~(12'(m)) : 12'(m);
      if (stall) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if (lat && i == 5) chk("valid_before_last", res_valid, 0);
      send_beat(neg, mag, (i == last_at - 1));
    end
    if (nb == 6 && get) collect(lat);
  endtask

  initial begin
    rst_n     = 1'b0;
    pp_valid  = 1'b0;
    pp_mag    = '0;
    pp_neg    = 1'b0;
    pp_last   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_product", res_product, 0);
    chk("rst_err", res_err, 0);
    chk("rst_ready", pp_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    send_prod(5, 3, 0, 6, 6, 0, 1);
    send_prod(3, 2, 0, 6, 6, 1, 1);
    send_prod(2047, 2047, 0, 6, 6, 0, 1);
    send_prod(2047, 2047, 1, 6, 6, 0, 1);
    for (int k = 0; k < 3; k++)
      send_prod($urandom_range(0, 2047), $urandom_range(0, 2047),
                1, 6, 6, 0, 1);

    // backpressure: result held while a beat is offered
    send_prod(7, 5, 0, 6, 6, 0, 0);
    pp_valid = 1'b1;
    pp_neg   = 1'b0;
    pp_mag   = 12'h123;
    pp_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", pp_ready, 0);
      chk("hold_valid", res_valid, 1);
      chk("hold_product", res_product, 35);
    end
    pp_valid = 1'b0;
    collect(0);
    send_prod(100, 1000, 0, 6, 6, 0, 1);

    // reset mid-product discards the partial sum and ignores beats
    send_prod(5, 3, 0, 6, 3, 0, 0);
    rst_n    = 1'b0;
    pp_valid = 1'b1;
    pp_mag   = 12'h7FF;
    @(negedge clk);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_product", res_product, 0);
    chk("mid_rst_ready", pp_ready, 1);
    rst_n    = 1'b1;
    pp_valid = 1'b0;
    @(negedge clk);
    send_prod(3, 2, 0, 6, 6, 0, 1);

    // misplaced pp_last still ends the product after six beats
    send_prod(5, 3, 0, 4, 6, 0, 1);
    send_prod(9, 11, 0, 6, 6, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
